tdc_pulsegen: RTL and testbench

- CSR-mapped programmable pulse-train generator that produces calibration and test stimulus for the stdc_hostif TDC channels.
- Sits upstream of the TDC. Its pulse_o output drives a TDC signal input, or a test output buffer, on the SPEC board.
- Slave on the shared CSR bus behind csrbrg. Its read data is OR-combined with the other CSR slaves.
- Raises an interrupt when a finite burst completes.

---
 rtl/tdc_pulsegen.sv | 169 ++++++++++++++++
 tb/tb_tdc_pulsegen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_pulsegen.sv
// CSR-programmable pulse-train generator for TDC calibration stimulus.
// Produces finite bursts or continuous trains; flags burst completion via irq.
module tdc_pulsegen #(
  parameter logic [3:0] csr_addr = 4'h2,
  parameter int         width    = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic        pulse_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [width-1:0] W_ONE = {{(width-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [width-1:0] r_high;
  logic [width-1:0] r_low;
  logic [width-1:0] r_count;
  logic [width-1:0] r_rem;
  logic [width-1:0] r_cnt;
  logic             r_cont;
  logic             r_irq_en;
  logic             r_done;
  logic             r_pulse;
  logic [31:0]      r_do;

  logic             w_sel;
  logic             w_wr;
  logic [2:0]       w_idx;
  logic             w_wr_ctrl;
  logic             w_start;
  logic             w_stop;
  logic             w_cont;
  logic             w_clr;
  logic             w_busy;
  logic             w_expire;
  logic [width-1:0] w_hi_len;
  logic [width-1:0] w_lo_len;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_sel     = (csr_a[13:10] == csr_addr);
  assign w_wr      = csr_we & w_sel;
  assign w_idx     = csr_a[2:0];
  assign w_wr_ctrl = w_wr && (w_idx == 3'd0);
  assign w_stop    = w_wr_ctrl & csr_di[1];
  assign w_start   = w_wr_ctrl & csr_di[0] & ~csr_di[1];
  // START decision sees the CONT bit carried by the same write
  assign w_cont    = w_wr_ctrl ? csr_di[2] : r_cont;
  assign w_clr     = w_wr && (w_idx == 3'd4) && csr_di[0];
  assign w_busy    = (r_state != S_IDLE);
  assign w_expire  = (r_cnt <= W_ONE);
  assign w_hi_len  = (r_high == '0) ? W_ONE : r_high;
  assign w_lo_len  = (r_low == '0) ? W_ONE : r_low;
  assign w_unused  = ^{csr_a[9:3], csr_di};

  always_comb begin
    w_rd = '0;
    case (w_idx)
      3'd0: begin
        w_rd[0] = w_busy;
        w_rd[2] = r_cont;
        w_rd[3] = r_irq_en;
      end
      3'd1: w_rd[width-1:0] = r_high;
      3'd2: w_rd[width-1:0] = r_low;
      3'd3: w_rd[width-1:0] = r_count;
      3'd4: begin
        w_rd[0]          = r_done;
        w_rd[16 +: width] = r_rem;
      end
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_high   <= W_ONE;
      r_low    <= W_ONE;
      r_count  <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_cont   <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_pulse  <= 1'b0;
      r_do     <= '0;
    end else begin
      r_do <= w_sel ? w_rd : '0;
      if (w_wr) begin
        case (w_idx)
          3'd0: begin
            r_cont   <= csr_di[2];
            r_irq_en <= csr_di[3];
          end
          3'd1: r_high  <= csr_di[width-1:0];
          3'd2: r_low   <= csr_di[width-1:0];
          3'd3: r_count <= csr_di[width-1:0];
          default: ;
        endcase
      end
      // a completion below overrides this clear
      if (w_clr) r_done <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
        r_pulse <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              if (r_count != '0 || w_cont) begin
                r_state <= S_HIGH;
                r_pulse <= 1'b1;
                r_cnt   <= w_hi_len;
                r_rem   <= r_count;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_HIGH: begin
            if (w_expire) begin
              r_state <= S_LOW;
              r_pulse <= 1'b0;
              r_cnt   <= w_lo_len;
              if (!r_cont && r_rem != '0) r_rem <= r_rem - W_ONE;
            end else begin
              r_cnt <= r_cnt - W_ONE;
            end
          end
          S_LOW: begin
            if (w_expire) begin
              if (r_cont || r_rem != '0) begin
                r_state <= S_HIGH;
                r_pulse <= 1'b1;
                r_cnt   <= w_hi_len;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - W_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_pulse <= 1'b0;
          end
        endcase
      end
    end
  end

  assign csr_do  = r_do;
  assign pulse_o = r_pulse;
  assign irq     = r_done & r_irq_en;

endmodule

// File: tb/tb_tdc_pulsegen.sv
// Self-checking bench for tdc_pulsegen.
// Expected waveforms come from a phase-list model of the pulse train.
module tb_tdc_pulsegen;

  localparam logic [3:0] PAGE = 4'h2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] a = '0;
  logic        we = 1'b0;
  logic [31:0] di = '0;
  logic [31:0] dout;
  logic        irq;
  logic        pulse;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdc_pulsegen dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .csr_a    (a),
    .csr_we   (we),
    .csr_di   (di),
    .csr_do   (dout),
    .irq      (irq),
    .pulse_o  (pulse)
  );

  task automatic cyc(input logic w, input logic [3:0] pg,
                     input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    we = w;
    a  = {pg, 7'd0, idx};
    di = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    cyc(1'b1, PAGE, idx, d);
  endtask

  task automatic rd(input logic [2:0] idx);
    cyc(1'b0, PAGE, idx, 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, PAGE, 3'd5, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_r [5];
    exp_r = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if (pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse got %b want 0", pulse);
    end
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
    n_run++;
    if (dout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_csr_do got %h want 0", dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(3'(i));
      n_run++;
      if (dout !== exp_r[i]) begin
        n_fail++;
        $display("FAIL reset_reg%0d got %h want %h", i, dout, exp_r[i]);
      end
    end
    cyc(1'b0, 4'h3, 3'd1, 32'd0);
    n_run++;
    if (dout !== 32'h0) begin
      n_fail++;
      $display("FAIL other_page got %h want 0", dout);
    end
  endtask

  task automatic test_burst(input int h, input int l, input int cnt,
                            input bit ien);
    bit q[$];
    int hp, lp, total;
    hp = (h == 0) ? 1 : h;
    lp = (l == 0) ? 1 : l;
    for (int p = 0; p < cnt; p++) begin
      for (int i = 0; i < hp; i++) q.push_back(1'b1);
      for (int i = 0; i < lp; i++) q.push_back(1'b0);
    end
    total = q.size();
    wr(3'd1, 32'(h));
    wr(3'd2, 32'(l));
    wr(3'd3, 32'(cnt));
    wr(3'd0, {28'd0, ien, 3'b001});
    for (int c = 1; c <= total + 2; c++) begin
      logic ep, ei;
      if (c > 1) idle();
      ep = (c <= total) ? q[c-1] : 1'b0;
      ei = ien && (c > total);
      n_run++;
      if (pulse !== ep) begin
        n_fail++;
        $display("FAIL burst_pulse h%0d l%0d n%0d c%0d got %b want %b",
                 h, l, cnt, c, pulse, ep);
      end
      n_run++;
      if (irq !== ei) begin
        n_fail++;
        $display("FAIL burst_irq h%0d l%0d n%0d c%0d got %b want %b",
                 h, l, cnt, c, irq, ei);
      end
    end
    rd(3'd4);
    n_run++;
    if (dout !== 32'h1) begin
      n_fail++;
      $display("FAIL burst_status got %h want 1", dout);
    end
    wr(3'd4, 32'h1);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_w1c_irq got %b want 0", irq);
    end
    rd(3'd4);
    n_run++;
    if (dout !== 32'h0) begin
      n_fail++;
      $display("FAIL burst_status_clr got %h want 0", dout);
    end
  endtask

  task automatic test_cont_stop(input int h, input int l);
    int hp, lp, p, n;
    hp = (h == 0) ? 1 : h;
    lp = (l == 0) ? 1 : l;
    p  = hp + lp;
    n  = 3 * p;
    wr(3'd1, 32'(h));
    wr(3'd2, 32'(l));
    wr(3'd0, 32'h5);
    for (int c = 1; c <= n; c++) begin
      logic ep;
      if (c > 1) idle();
      ep = (((c - 1) % p) < hp);
      n_run++;
      if (pulse !== ep) begin
        n_fail++;
        $display("FAIL cont_pulse h%0d l%0d c%0d got %b want %b",
                 h, l, c, pulse, ep);
      end
    end
    wr(3'd0, 32'h2);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) idle();
      n_run++;
      if (pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_pulse c%0d got %b want 0", c, pulse);
      end
    end
    rd(3'd0);
    n_run++;
    if (dout !== 32'h0) begin
      n_fail++;
      $display("FAIL stop_ctrl got %h want 0", dout);
    end
    rd(3'd4);
    n_run++;
    if (dout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_done got %b want 0", dout[0]);
    end
  endtask

  task automatic test_count_zero();
    wr(3'd3, 32'd0);
    wr(3'd0, 32'h9);
    n_run++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_irq got %b want 1", irq);
    end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) idle();
      n_run++;
      if (pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_pulse c%0d got %b want 0", c, pulse);
      end
    end
    rd(3'd0);
    n_run++;
    if (dout !== 32'h8) begin
      n_fail++;
      $display("FAIL zero_ctrl got %h want 8", dout);
    end
    wr(3'd4, 32'h1);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_w1c got %b want 0", irq);
    end
  endtask

  task automatic test_midburst();
    bit q[$];
    int total;
    for (int i = 0; i < 2; i++) q.push_back(1'b1);
    for (int i = 0; i < 2; i++) q.push_back(1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) q.push_back(1'b1);
      for (int i = 0; i < 2; i++) q.push_back(1'b0);
    end
    total = q.size();
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd4);
    wr(3'd0, 32'h1);
    for (int c = 1; c <= total + 2; c++) begin
      logic ep;
      if (c == 3) wr(3'd1, 32'd6);
      else if (c == 8) wr(3'd0, 32'h1);
      else if (c > 1) idle();
      ep = (c <= total) ? q[c-1] : 1'b0;
      n_run++;
      if (pulse !== ep) begin
        n_fail++;
        $display("FAIL mid_pulse c%0d got %b want %b", c, pulse, ep);
      end
    end
    rd(3'd4);
    n_run++;
    if (dout !== 32'h1) begin
      n_fail++;
      $display("FAIL mid_status got %h want 1", dout);
    end
    wr(3'd4, 32'h1);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] exp_r [4];
    exp_r = '{32'h0, 32'h1, 32'h1, 32'h0};
    wr(3'd1, 32'd4);
    wr(3'd2, 32'd4);
    wr(3'd0, 32'h5);
    idle();
    n_run++;
    if (pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got %b want 1", pulse);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_run++;
    if (pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pulse got %b want 0", pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle();
      n_run++;
      if (pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_after c%0d got %b want 0", c, pulse);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd(3'(i));
      n_run++;
      if (dout !== exp_r[i]) begin
        n_fail++;
        $display("FAIL rstmid_reg%0d got %h want %h", i, dout, exp_r[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst(3, 5, 2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      test_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                 int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end
    test_cont_stop(0, 0);
    for (int k = 0; k < 2; k++) begin
      test_cont_stop(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    test_count_zero();
    test_midburst();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
